// File: rtl/blocking.sv
// -----------------------------------------------------------------------------
// blocking
//   Self-sequencing four-register datapath. Each clock edge evaluates the
//   registers a, b, c, d in that fixed order. Every later update sees the values
//   that earlier updates produced in the same cycle, which is the behaviour of
//   blocking assignments. After reset the block runs LOAD once and then repeats
//   the CHAIN..SWAP..ROTATE loop forever. All arithmetic wraps modulo 2^32.
//
// Parameters
//   INIT_A..INIT_D  values loaded into a..d by LOAD
//   CHAIN_CYCLES    consecutive CHAIN cycles per loop (0 is treated as 1)
//
// Ports
//   clk  in   1   rising-edge clock
//   rst  in   1   asynchronous, active-high reset
//   a    out  32  register a (registered)
//   b    out  32  register b (registered)
//   c    out  32  register c (registered)
//   d    out  32  register d (registered)
// -----------------------------------------------------------------------------
module blocking #(
  parameter logic [31:0] INIT_A       = 32'd10,
  parameter logic [31:0] INIT_B       = 32'd20,
  parameter logic [31:0] INIT_C       = 32'd30,
  parameter logic [31:0] INIT_D       = 32'd40,
  parameter int unsigned CHAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] c,
  output logic [31:0] d
);

  // A CHAIN_CYCLES of zero still runs one CHAIN cycle per loop.
  localparam int unsigned CHAIN_EFF  = (CHAIN_CYCLES == 0) ? 1 : CHAIN_CYCLES;
  localparam logic [31:0] CHAIN_LAST = 32'(CHAIN_EFF);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    CHAIN  = 2'd1,
    SWAP   = 2'd2,
    ROTATE = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] count;

  logic [31:0] chain_a;
  logic [31:0] chain_b;
  logic [31:0] chain_c;
  logic [31:0] chain_d;
  logic [31:0] count_next;

  // CHAIN results: each term feeds on the one updated just before it.
  always_comb begin
    chain_a    = a + 32'd1;
    chain_b    = b + chain_a;
    chain_c    = c + chain_b;
    chain_d    = d + chain_c;
    count_next = count + 32'd1;
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= 32'd0;
      b     <= 32'd0;
      c     <= 32'd0;
      d     <= 32'd0;
      count <= 32'd0;
      state <= LOAD;
    end else begin
      case (state)
        LOAD: begin
          a     <= INIT_A;
          b     <= INIT_B;
          c     <= INIT_C;
          d     <= INIT_D;
          count <= 32'd0;
          state <= CHAIN;
        end
        CHAIN: begin
          a     <= chain_a;
          b     <= chain_b;
          c     <= chain_c;
          d     <= chain_d;
          count <= count_next;
          if (count_next < CHAIN_LAST) begin
            state <= CHAIN;
          end else begin
            state <= SWAP;
          end
        end
        SWAP: begin
          // Naive in-order swap: b takes the a it just overwrote, so both
          // halves end up holding the old b and the old d.
          a     <= b;
          b     <= b;
          c     <= d;
          d     <= d;
          state <= ROTATE;
        end
        ROTATE: begin
          // d reads a after a has already taken b, so d receives the old b.
          a     <= b;
          b     <= c;
          c     <= d;
          d     <= b;
          count <= 32'd0;
          state <= CHAIN;
        end
        default: begin
          count <= 32'd0;
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blocking.sv
module tb_blocking;

  typedef logic [3:0][31:0] quad_t;  // [0]=a [1]=b [2]=c [3]=d

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } vec_t;

  logic clk;
  logic rst;

  logic [31:0] a0, b0, c0, d0;  // defaults
  logic [31:0] a1, b1, c1, d1;  // wrap case
  logic [31:0] a2, b2, c2, d2;  // CHAIN_CYCLES = 0

  int tests;
  int fails;

  quad_t mdl  [3];
  int    kk   [3];
  quad_t init [3];
  int    eff  [3];
  quad_t dq   [3];

  blocking dut0 (.clk(clk), .rst(rst), .a(a0), .b(b0), .c(c0), .d(d0));

  blocking #(
    .INIT_A(32'hFFFF_FFFF), .INIT_B(32'd0), .INIT_C(32'd0), .INIT_D(32'd0)
  ) dut1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1));

  blocking #(.CHAIN_CYCLES(0)) dut2 (.clk(clk), .rst(rst), .a(a2), .b(b2), .c(c2), .d(d2));

  assign dq[0] = {d0, c0, b0, a0};
  assign dq[1] = {d1, c1, b1, a1};
  assign dq[2] = {d2, c2, b2, a2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: k counts edges executed since reset; edge 0 is LOAD, then
  // the loop is eff CHAIN steps, one SWAP, one ROTATE, applied in order.
  function automatic quad_t model_next(quad_t v, quad_t iv, int k, int e);
    quad_t r;
    int    ph;
    r = v;
    if (k == 0) return iv;
    ph = (k - 1) % (e + 2);
    if (ph < e) begin
      r[0] = r[0] + 32'd1;
      r[1] = r[1] + r[0];
      r[2] = r[2] + r[1];
      r[3] = r[3] + r[2];
    end else if (ph == e) begin
      r[0] = r[1]; r[1] = r[0]; r[2] = r[3]; r[3] = r[2];
    end else begin
      r[0] = r[1]; r[1] = r[2]; r[2] = r[3]; r[3] = r[0];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("%s dut%0d reg%0d", tag, i, j), dq[i][j], mdl[i][j]);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mdl[i] = '0;
      kk[i]  = 0;
    end
  endtask

  // One clock edge; the model follows unless reset is held.
  task automatic do_edge();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        mdl[i] = model_next(mdl[i], init[i], kk[i], eff[i]);
        kk[i]++;
      end
    end
    @(negedge clk);
  endtask

  // Reset pulse strictly between edges; outputs must clear with no edge.
  task automatic mid_reset(input string tag);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk_model(tag);
    #1 rst = 1'b0;
  endtask

  vec_t tbl [6];

  initial begin
    tests = 0;
    fails = 0;
    init[0] = {32'd40, 32'd30, 32'd20, 32'd10};
    init[1] = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    init[2] = {32'd40, 32'd30, 32'd20, 32'd10};
    eff[0] = 2; eff[1] = 2; eff[2] = 1;

    tbl[0] = '{32'd10, 32'd20,  32'd30,  32'd40};
    tbl[1] = '{32'd11, 32'd31,  32'd61,  32'd101};
    tbl[2] = '{32'd12, 32'd43,  32'd104, 32'd205};
    tbl[3] = '{32'd43, 32'd43,  32'd205, 32'd205};
    tbl[4] = '{32'd43, 32'd205, 32'd205, 32'd43};
    tbl[5] = '{32'd44, 32'd249, 32'd454, 32'd497};

    // Reset state before any edge completes.
    rst = 1'b1;
    model_reset();
    #2;
    chk("reset a", a0, 32'd0);
    chk("reset d", d0, 32'd0);
    chk_model("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors for the default instance, edges 1..6.
    for (int e = 0; e < 6; e++) begin
      do_edge();
      chk($sformatf("edge%0d a", e + 1), a0, tbl[e].a);
      chk($sformatf("edge%0d b", e + 1), b0, tbl[e].b);
      chk($sformatf("edge%0d c", e + 1), c0, tbl[e].c);
      chk($sformatf("edge%0d d", e + 1), d0, tbl[e].d);
      chk_model($sformatf("edge%0d", e + 1));
      if (e == 1) begin
        // Wrap instance: first CHAIN from FFFF_FFFF yields all zero.
        chk("wrap a", a1, 32'd0);
        chk("wrap b", b1, 32'd0);
        chk("wrap c", c1, 32'd0);
        chk("wrap d", d1, 32'd0);
      end
      if (e == 2) begin
        chk("cc0 swap a", a2, 32'd31);
        chk("cc0 swap d", d2, 32'd101);
      end
      if (e == 4) begin
        // Single CHAIN then SWAP/ROTATE, then CHAIN again.
        chk("cc0 chain2 a", a2, 32'd32);
        chk("cc0 chain2 b", b2, 32'd133);
        chk("cc0 chain2 c", c2, 32'd234);
        chk("cc0 chain2 d", d2, 32'd265);
      end
    end

    // Mid-run asynchronous reset, then the next edge loads again.
    mid_reset("midreset");
    chk("midreset a", a0, 32'd0);
    chk("midreset c", c0, 32'd0);
    do_edge();
    chk("reload a", a0, 32'd10);
    chk("reload d", d0, 32'd40);
    chk_model("reload");

    // Randomised run: long free-running stretches with occasional resets.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 39));
      if (r == 0) begin
        mid_reset("rand midreset");
      end else if (r == 1) begin
        rst = 1'b1;
        model_reset();
        do_edge();
        chk_model("rand held reset");
        rst = 1'b0;
      end else begin
        do_edge();
        chk_model("rand run");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
